// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA stream output engine.
package vga_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  // Counter width for a counter running 0..total-1, never narrower than 1 bit.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with region decode. Order per axis:
// active, front porch, sync, back porch.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk,
  input  logic reset,
  output logic active_o,
  output logic hs_raw_o,
  output logic vs_raw_o,
  output logic at_origin_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_raw_o    = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
  assign vs_raw_o    = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
  assign at_origin_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_stream_out.sv
// Avalon-ST pixel stream to VGA DAC pins, with frame lock, error recovery
// and sticky status. All pin outputs are registered one clock after the counters.
module vga_stream_out
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter logic [3*COLOR_BITS-1:0] UNDERFLOW_COLOR = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3*COLOR_BITS-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  output logic                    in_ready,
  input  logic                    clear_status,
  output logic                    underflow,
  output logic                    sop_err,
  output logic                    frame_start,
  output logic [COLOR_BITS-1:0]   VGA_R,
  output logic [COLOR_BITS-1:0]   VGA_G,
  output logic [COLOR_BITS-1:0]   VGA_B,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N
);

  logic active, hs_raw, vs_raw, at_origin;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .active_o   (active),
    .hs_raw_o   (hs_raw),
    .vs_raw_o   (vs_raw),
    .at_origin_o(at_origin)
  );

  lock_state_t             state_q, state_d;
  logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;
  logic                    blank_n_q, hs_q, vs_q, fs_q;
  logic                    underflow_q, underflow_d, sop_err_q, sop_err_d;
  logic                    uf_set, se_set;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    rgb_d    = '0;
    uf_set   = 1'b0;
    se_set   = 1'b0;
    case (state_q)
      HUNT: begin
        in_ready = !(in_valid && in_sop);
        if (in_valid && in_sop) state_d = ARMED;
      end
      ARMED: begin
        // The held SOP beat is only taken at the raster origin.
        if (in_valid && in_sop) begin
          if (at_origin) begin
            in_ready = 1'b1;
            rgb_d    = in_data;
            state_d  = LOCKED;
          end
        end else begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        // A beat is refused only when its SOP flag disagrees with the raster position.
        in_ready = active && !(in_valid && (in_sop != at_origin));
        if (active) begin
          if (!in_valid) begin
            rgb_d   = UNDERFLOW_COLOR;
            uf_set  = 1'b1;
            state_d = HUNT;
          end else if (in_sop != at_origin) begin
            rgb_d   = UNDERFLOW_COLOR;
            se_set  = 1'b1;
            state_d = in_sop ? ARMED : HUNT;
          end else begin
            rgb_d = in_data;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign underflow_d = (underflow_q & ~clear_status) | uf_set;
  assign sop_err_d   = (sop_err_q & ~clear_status) | se_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      rgb_q       <= '0;
      blank_n_q   <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      fs_q        <= 1'b0;
      underflow_q <= 1'b0;
      sop_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rgb_q       <= rgb_d;
      blank_n_q   <= active;
      hs_q        <= hs_raw ? HS_POL : ~HS_POL;
      vs_q        <= vs_raw ? VS_POL : ~VS_POL;
      fs_q        <= at_origin;
      underflow_q <= underflow_d;
      sop_err_q   <= sop_err_d;
    end
  end

  assign VGA_R       = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
  assign VGA_G       = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign VGA_B       = rgb_q[COLOR_BITS-1:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = fs_q;
  assign underflow   = underflow_q;
  assign sop_err     = sop_err_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Self-checking bench: segment table drives a beat source; per-cycle expected
// pins are queued and compared one clock later.
module tb_vga_stream_out;

  localparam int D_AUTO = 0, D_IDLE = 1, D_UF = 2, D_SE = 3, D_RST = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] in_data = '0;
  logic       in_valid = 1'b0, in_sop = 1'b0, clear_status = 1'b0;
  logic       in_ready, underflow, sop_err, frame_start;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  vga_stream_out #(
    .COLOR_BITS(2),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .UNDERFLOW_COLOR(6'h3F)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
    .clear_status(clear_status), .underflow(underflow), .sop_err(sop_err),
    .frame_start(frame_start),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] rgb;
    logic bn, hs, vs, fs, uf, se, sn;
  } pins_t;

  // rb: -1 keep SOP schedule, 0 current beat becomes SOP, 1 suppress SOPs.
  // rdy: 0/1 explicit, 2 = follows the active region.
  typedef struct {
    int t0; int t1; logic v; logic clr; int rb; int disp; int rdy; int chk;
  } seg_t;

  pins_t exp_q[$];
  seg_t  segs[$];
  int    n_run = 0, n_fail = 0;
  int    t = 0, k = 0, base = 0;
  logic  sb_uf = 1'b0, sb_se = 1'b0;

  function automatic seg_t mk(int t0, int t1, logic v, logic clr, int rb, int disp, int rdy, int chk);
    seg_t s;
    s.t0 = t0; s.t1 = t1; s.v = v; s.clr = clr; s.rb = rb; s.disp = disp; s.rdy = rdy; s.chk = chk;
    return s;
  endfunction

  task automatic check_pins();
    pins_t e, a;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    a.rgb = {vga_r, vga_g, vga_b}; a.bn = vga_blank_n; a.hs = vga_hs; a.vs = vga_vs;
    a.fs = frame_start; a.uf = underflow; a.se = sop_err; a.sn = vga_sync_n;
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL pins t=%0d: got rgb=%h bn=%b hs=%b vs=%b fs=%b uf=%b se=%b sn=%b, want rgb=%h bn=%b hs=%b vs=%b fs=%b uf=%b se=%b sn=%b",
               t, a.rgb, a.bn, a.hs, a.vs, a.fs, a.uf, a.se, a.sn,
               e.rgb, e.bn, e.hs, e.vs, e.fs, e.uf, e.se, e.sn);
    end
  endtask

  task automatic cyc(input logic v, input logic clr, input int disp, input int rdy);
    int    h, vv;
    logic  act, er;
    pins_t e;
    check_pins();
    h   = t % 8;
    vv  = (t / 8) % 6;
    act = (h < 4) && (vv < 3);
    in_valid     = v;
    in_sop       = v && (k >= base) && (((k - base) % 12) == 0);
    in_data      = 6'(k);
    clear_status = clr;
    #1;
    er = (rdy == 2) ? act : (rdy != 0);
    n_run++;
    if (in_ready !== er) begin
      n_fail++;
      $display("FAIL ready t=%0d: got %b want %b", t, in_ready, er);
    end
    sb_uf = (sb_uf & !clr) | (disp == D_UF);
    sb_se = (sb_se & !clr) | (disp == D_SE);
    e.sn = 1'b0;
    e.hs = !(h == 5 || h == 6);
    e.vs = !(vv == 4);
    e.fs = (h == 0) && (vv == 0);
    e.uf = sb_uf;
    e.se = sb_se;
    e.bn = act;
    e.rgb = '0;
    if (act) begin
      if (disp == D_AUTO) e.rgb = in_data;
      else if (disp == D_UF || disp == D_SE) e.rgb = 6'h3F;
    end
    exp_q.push_back(e);
    if (v && in_ready) k++;
    @(negedge clk);
    t++;
  endtask

  task automatic do_reset(input int n);
    pins_t e;
    e = '{rgb: 6'h0, bn: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, uf: 1'b0, se: 1'b0, sn: 1'b0};
    for (int i = 0; i < n; i++) begin
      check_pins();
      reset = 1'b1; in_valid = 1'b1; in_sop = 1'b0; clear_status = 1'b0;
      #1;
      n_run++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ready: got %b want 0", in_ready);
      end
      exp_q.push_back(e);
      @(negedge clk);
    end
    reset = 1'b0; t = 0; sb_uf = 1'b0; sb_se = 1'b0;
  endtask

  initial begin
    // ideal stream: lock one frame after reset, then two clean frames
    segs.push_back(mk(0,   2,   0, 0, -1, D_RST,  0, -1));
    segs.push_back(mk(0,   0,   1, 0,  0, D_IDLE, 0, -1));
    segs.push_back(mk(1,   47,  1, 0, -1, D_IDLE, 0, -1));
    segs.push_back(mk(48,  144, 1, 0, -1, D_AUTO, 2, 25));
    // mid-frame start: five stray beats discarded
    segs.push_back(mk(0,   2,   0, 0, -1, D_RST,  0, -1));
    segs.push_back(mk(0,   4,   1, 0,  1, D_IDLE, 1, -1));
    segs.push_back(mk(5,   5,   1, 0,  0, D_IDLE, 0, -1));
    segs.push_back(mk(6,   47,  1, 0, -1, D_IDLE, 0, -1));
    segs.push_back(mk(48,  105, 1, 0, -1, D_AUTO, 2, 18));
    // underflow at pixel (2,1), relock next frame
    segs.push_back(mk(106, 106, 0, 0, -1, D_UF,   1, -1));
    segs.push_back(mk(107, 112, 1, 0, -1, D_IDLE, 1, -1));
    segs.push_back(mk(113, 143, 1, 0, -1, D_IDLE, 0, -1));
    segs.push_back(mk(144, 202, 1, 0, -1, D_AUTO, 2, 43));
    // early SOP at pixel 7, held and shown at next origin
    segs.push_back(mk(203, 203, 1, 0,  0, D_SE,   0, -1));
    segs.push_back(mk(204, 239, 1, 0, -1, D_IDLE, 0, -1));
    segs.push_back(mk(240, 288, 1, 0, -1, D_AUTO, 2, 13));
    // clear coinciding with new underflow, then a lone clear
    segs.push_back(mk(289, 289, 0, 1, -1, D_UF,   1, -1));
    segs.push_back(mk(290, 300, 1, 0, -1, D_IDLE, 1, -1));
    segs.push_back(mk(301, 309, 1, 0, -1, D_IDLE, 0, -1));
    segs.push_back(mk(310, 310, 1, 1, -1, D_IDLE, 0, -1));
    segs.push_back(mk(311, 335, 1, 0, -1, D_IDLE, 0, -1));
    segs.push_back(mk(336, 399, 1, 0, -1, D_AUTO, 2, 44));
    // reset at (3,2) with underflow pending, then relock from HUNT
    segs.push_back(mk(400, 400, 0, 0, -1, D_UF,   1, -1));
    segs.push_back(mk(401, 402, 1, 0, -1, D_IDLE, 1, -1));
    segs.push_back(mk(0,   2,   0, 0, -1, D_RST,  0, -1));
    segs.push_back(mk(0,   2,   1, 0,  1, D_IDLE, 1, -1));
    segs.push_back(mk(3,   3,   1, 0,  0, D_IDLE, 0, -1));
    segs.push_back(mk(4,   47,  1, 0, -1, D_IDLE, 0, -1));
    segs.push_back(mk(48,  52,  1, 0, -1, D_AUTO, 2, 4));

    @(negedge clk);
    for (int i = 0; i < segs.size(); i++) begin
      if (segs[i].disp == D_RST) begin
        do_reset(segs[i].t1);
      end else begin
        for (int c = segs[i].t0; c <= segs[i].t1; c++) begin
          if (c == segs[i].t0) begin
            if (segs[i].rb == 0) base = k;
            else if (segs[i].rb == 1) base = k + 100000;
          end
          cyc(segs[i].v, segs[i].clr, segs[i].disp, segs[i].rdy);
        end
        if (segs[i].chk >= 0) begin
          n_run++;
          if (k - base != segs[i].chk) begin
            n_fail++;
            $display("FAIL beats seg=%0d: got %0d want %0d", i, k - base, segs[i].chk);
          end
        end
      end
    end
    check_pins();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_stream_out.md
# vga_stream_out

Parametrised VGA output engine. It consumes an Avalon-ST pixel stream, with a start-of-packet marker on the first pixel of each frame, and drives the board DAC pins: R, G, B, HS, VS, BLANK_N and SYNC_N. Resolution, porch and sync widths, sync polarity and colour depth are all parameters. Unlike the fixed 640x480 controller inside the current Computer_System, it locks to frame boundaries, recovers automatically from stream underflow and misaligned frames, and reports both error types through sticky status bits. It sits between the pixel DMA/frame-buffer reader and the VGA pins in the pixel clock domain.

## Interface
Parameters:
- COLOR_BITS, default 8: width of each of R, G and B.
- H_ACTIVE, H_FP, H_SYNC, H_BP, defaults 640, 16, 96, 48: horizontal active, front porch, sync and back porch widths, in pixels.
- V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical active, front porch, sync and back porch heights, in lines.
- HS_POL, default 0: asserted level of HS. VS_POL, default 0: asserted level of VS.
- UNDERFLOW_COLOR, default all-ones, 3*COLOR_BITS wide: {R,G,B} shown on a stream error.

Ports:
- clk, in, 1: pixel clock.
- reset, in, 1: synchronous, active-high.
- in_data, in, 3*COLOR_BITS: {R,G,B} pixel.
- in_valid, in, 1: source has a beat.
- in_sop, in, 1: beat is pixel (0,0) of a frame.
- in_ready, out, 1: beat is consumed when in_valid && in_ready.
- clear_status, in, 1: single-cycle pulse; clears both sticky bits.
- underflow, out, 1: sticky; set when the stream was empty during the active region.
- sop_err, out, 1: sticky; set on a frame-alignment error.
- frame_start, out, 1: one-cycle pulse, aligned with the first active pixel on the pins.
- VGA_R, VGA_G, VGA_B, out, COLOR_BITS each: colour outputs.
- VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, out, 1 each: sync and blanking outputs.

## Operation
Timing counters:
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1, wrapping to 0.
- Line order is active, then front porch, then sync, then back porch. The same order applies vertically.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- HS is asserted (= HS_POL) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. VS follows the same rule on v_cnt with VS_POL.

Lock state machine:
- HUNT:
  - in_ready = !(in_valid && in_sop), so non-SOP beats are discarded.
  - A valid SOP beat is held, not consumed. Move to ARMED.
  - Pins show blank.
- ARMED:
  - in_ready = 0.
  - When h_cnt=0, v_cnt=0 and in_valid && in_sop, move to LOCKED and consume that beat in the same cycle.
  - If in_sop drops while held, return to HUNT.
- LOCKED:
  - in_ready = active. Each active cycle with in_valid consumes one beat and displays it.
  - Active cycle with !in_valid: display UNDERFLOW_COLOR, set underflow, go to HUNT.
  - Active cycle with in_valid && in_sop at any position other than (0,0): do not consume, display UNDERFLOW_COLOR, set sop_err, go to ARMED.
  - At (0,0) with in_valid && !in_sop: do not consume, display UNDERFLOW_COLOR, set sop_err, go to HUNT.
  - Blanking cycles never consume.

Outputs and status:
- Blanking cycles output RGB = 0 and BLANK_N = 0.
- In HUNT and ARMED, active cycles output RGB = 0 with BLANK_N = 1. Sync timing is never interrupted.
- VGA_SYNC_N is constant 0 (no sync-on-green).
- clear_status has priority under set in the same cycle: the bit is set.
- reset:
  - Counters go to 0, state goes to HUNT and sticky bits clear.
  - in_ready = 0 while reset is high.
  - Registered outputs go to RGB = 0, BLANK_N = 0, HS = !HS_POL, VS = !VS_POL, frame_start = 0.
  - Reset mid-frame abandons the frame. No beat is consumed in a reset cycle.

## Timing
- All pin outputs, frame_start and the status bits are registered: they reflect counter position (h,v) one clock after the counters hold (h,v). Latency from the consumed beat to the pins is 1 clock.
- in_ready is combinational from state, counters, in_valid and in_sop.
- The first frame after reset begins with the counters at (0,0) on the first clock after reset deasserts.
- Parameter rule: every width must be at least 1. Counter width is $clog2 of the total.

## Structure
- Package vga_pkg holds the lock_state_t enum (HUNT, ARMED, LOCKED) and a function computing the counter width from the totals.
- Sub-module vga_timing_gen holds the h/v counters and produces active, hs_raw, vs_raw and at_origin. The top level holds the FSM, the output register and the status bits.

## Test plan
All scenarios use small timing: H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), 48 clocks per frame, COLOR_BITS=2, both polarities 0.
- Ideal source: always-valid stream with SOP on every 12th beat -> two full frames pass with no status set. Pins show pixels in order. HS is low at h=5,6. VS is low on v=4. frame_start pulses every 48 clocks.
- Starting mid-frame: source begins with 5 non-SOP beats, then SOP -> the 5 beats are discarded in HUNT. Lock occurs at the next (0,0). Zero underflow or sop_err.
- Underflow: in_valid drops for 1 cycle at pixel (2,1) -> that pixel shows 6'h3F, underflow=1, state HUNT. The next frame relocks on SOP.
- Early SOP: SOP arrives at pixel 7 -> beat not consumed, sop_err=1. That SOP beat is displayed at (0,0) of the next frame.
- Status clear: clear_status pulses in the same cycle as a new underflow -> underflow stays 1. A later lone clear_status -> 0.
- Reset mid-frame: reset asserted at (3,2) for 2 clocks -> in_ready=0, pins idle with HS=VS=1, BLANK_N=0. Counters restart at (0,0) and the FSM returns to HUNT.
